// File: rtl/read_store_buffer.sv
// read_store_buffer: batch store of reads for the SMEM pipeline.
// A batch is loaded over a cache-line stream, one read at a time. Each read is its
// sequence lines (one base per byte, compressed to 2 bits) followed by a param
// line and an ik line. Loaded reads are dispatched in order over a valid/ready
// handshake. Individual bases can be looked up through a 3-stage query pipeline.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   stall                 freezes the dispatch pointer and the query pipeline
//   batch_start/size      start a batch of size reads (IDLE only, size clamped)
//   batch_clear           end the batch and return to IDLE (SERVE only)
//   load_valid/ready/data load beat stream; load_done flags a complete batch
//   new_read_*            dispatch handshake, read index and its ik/param fields
//   reads_remaining       reads not yet dispatched
//   query_*               base lookup request and tagged, range-checked result
//   primary, L2_0..L2_3   fields of read 0's param and ik lines
module read_store_buffer #(
  parameter int unsigned CL        = 512,
  parameter int unsigned MAX_READ  = 64,
  parameter int unsigned RN_W      = 6,
  parameter int unsigned SEQ_LINES = 2,
  parameter int unsigned QP_W      = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            batch_start,
  input  logic [RN_W:0]   batch_size,
  input  logic            batch_clear,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [CL-1:0]   load_data,
  output logic            load_done,
  input  logic            new_read_ready,
  output logic            new_read_valid,
  output logic [RN_W-1:0] new_read_num,
  output logic [63:0]     new_ik_x0,
  output logic [63:0]     new_ik_x1,
  output logic [63:0]     new_ik_x2,
  output logic [63:0]     new_ik_info,
  output logic [6:0]      new_forward_i,
  output logic [6:0]      new_min_intv,
  output logic [RN_W:0]   reads_remaining,
  input  logic            query_valid,
  input  logic [RN_W-1:0] query_read_num,
  input  logic [QP_W-1:0] query_position,
  output logic            query_out_valid,
  output logic [7:0]      query_out_base,
  output logic            query_oob,
  output logic [63:0]     primary,
  output logic [63:0]     L2_0,
  output logic [63:0]     L2_1,
  output logic [63:0]     L2_2,
  output logic [63:0]     L2_3
);

  localparam int unsigned BPL   = CL / 8;
  localparam int unsigned RL    = SEQ_LINES * BPL;
  localparam int unsigned BI_W  = $clog2(BPL);
  localparam int unsigned LI_W  = (SEQ_LINES > 1) ? $clog2(SEQ_LINES) : 1;
  localparam int unsigned BEATS = SEQ_LINES + 2;
  localparam int unsigned BT_W  = $clog2(BEATS);

  typedef enum logic [1:0] {StIdle, StLoad, StServe} state_e;

  state_e          state_q, state_d;
  logic [RN_W:0]   n_q, n_d;
  logic [RN_W:0]   ptr_q, ptr_d;
  logic [RN_W-1:0] ld_read_q, ld_read_d;
  logic [BT_W-1:0] ld_beat_q, ld_beat_d;

  // Only the fields that ever leave the block are kept; read 0's extra fields
  // live in dedicated registers.
  logic [2*BPL-1:0] seq_q   [MAX_READ][SEQ_LINES];
  logic [13:0]      param_q [MAX_READ];
  logic [255:0]     ik_q    [MAX_READ];
  logic [63:0]      primary_q;
  logic [255:0]     l2_q;
  logic [2*BPL-1:0] seq_wr;

  logic            beat_fire;
  logic            dispatch_fire;
  logic [RN_W-1:0] rd_idx;

  // Query pipeline
  logic                 s1_valid_q, s1_oob_q;
  logic [2*BPL-1:0]     s1_line_q;
  logic [BI_W-1:0]      s1_idx_q;
  logic                 s2_valid_q, s2_oob_q;
  logic [1:0]           s2_base_q;
  logic                 qo_valid_q, qo_oob_q;
  logic [7:0]           qo_base_q;
  logic                 q_oob;
  logic [QP_W-BI_W-1:0] q_line;

  assign load_ready    = (state_q == StLoad);
  assign load_done     = (state_q == StServe);
  assign beat_fire     = load_ready & load_valid;
  assign dispatch_fire = new_read_valid & new_read_ready & ~stall;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    ptr_d     = ptr_q;
    ld_read_d = ld_read_q;
    ld_beat_d = ld_beat_q;
    unique case (state_q)
      StIdle: begin
        if (batch_start && (batch_size != '0)) begin
          state_d   = StLoad;
          n_d       = (batch_size > (RN_W+1)'(MAX_READ)) ? (RN_W+1)'(MAX_READ) : batch_size;
          ptr_d     = '0;
          ld_read_d = '0;
          ld_beat_d = '0;
        end
      end
      StLoad: begin
        if (beat_fire) begin
          if (ld_beat_q == BT_W'(BEATS - 1)) begin
            ld_beat_d = '0;
            ld_read_d = ld_read_q + 1'b1;
            if ({1'b0, ld_read_q} == (n_q - 1'b1)) state_d = StServe;
          end else begin
            ld_beat_d = ld_beat_q + 1'b1;
          end
        end
      end
      StServe: begin
        if (batch_clear) begin
          state_d = StIdle;
          ptr_d   = '0;
        end else if (dispatch_fire) begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      n_q       <= '0;
      ptr_q     <= '0;
      ld_read_q <= '0;
      ld_beat_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      ptr_q     <= ptr_d;
      ld_read_q <= ld_read_d;
      ld_beat_q <= ld_beat_d;
    end
  end

  // Keep the low two bits of every byte of a sequence line.
  always_comb begin
    seq_wr = '0;
    for (int k = 0; k < BPL; k++) seq_wr[2*k +: 2] = load_data[8*k +: 2];
  end

  always_ff @(posedge clk) begin
    if (reset_n && beat_fire) begin
      if (ld_beat_q < BT_W'(SEQ_LINES)) begin
        seq_q[ld_read_q][ld_beat_q[LI_W-1:0]] <= seq_wr;
      end else if (ld_beat_q == BT_W'(SEQ_LINES)) begin
        param_q[ld_read_q] <= {load_data[70:64], load_data[6:0]};
        if (ld_read_q == '0) primary_q <= load_data[191:128];
      end else begin
        ik_q[ld_read_q] <= load_data[255:0];
        if (ld_read_q == '0) l2_q <= load_data[511:256];
      end
    end
  end

  always_comb begin
    new_read_valid  = (state_q == StServe) && (ptr_q < n_q);
    rd_idx          = ptr_q[RN_W-1:0];
    new_read_num    = '1;
    new_ik_x0       = {16{4'h1}};
    new_ik_x1       = {16{4'h1}};
    new_ik_x2       = {16{4'h1}};
    new_ik_info     = {16{4'h1}};
    new_forward_i   = 7'h7F;
    new_min_intv    = 7'h7F;
    if (new_read_valid) begin
      new_read_num  = rd_idx;
      new_ik_x0     = ik_q[rd_idx][63:0];
      new_ik_x1     = ik_q[rd_idx][127:64];
      new_ik_x2     = ik_q[rd_idx][191:128];
      new_ik_info   = ik_q[rd_idx][255:192];
      new_forward_i = param_q[rd_idx][6:0];
      new_min_intv  = param_q[rd_idx][13:7];
    end
    reads_remaining = (state_q == StServe) ? (n_q - ptr_q) : '0;
  end

  assign primary = primary_q;
  assign L2_0    = l2_q[63:0];
  assign L2_1    = l2_q[127:64];
  assign L2_2    = l2_q[191:128];
  assign L2_3    = l2_q[255:192];

  // Range is judged against the batch as it stands when the query is sampled.
  assign q_line = query_position[QP_W-1:BI_W];
  assign q_oob  = (state_q != StServe) || ({1'b0, query_read_num} >= n_q) ||
                  ({1'b0, query_position} >= (QP_W+1)'(RL));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      qo_valid_q <= 1'b0;
      qo_oob_q   <= 1'b0;
      qo_base_q  <= 8'hFF;
    end else if (!stall) begin
      s1_valid_q <= query_valid;
      s2_valid_q <= s1_valid_q;
      qo_valid_q <= s2_valid_q;
      qo_oob_q   <= s2_valid_q & s2_oob_q;
      qo_base_q  <= (s2_valid_q && !s2_oob_q) ? {6'b0, s2_base_q} : 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_line_q <= seq_q[query_read_num][q_line];
      s1_idx_q  <= query_position[BI_W-1:0];
      s1_oob_q  <= q_oob;
      s2_base_q <= s1_line_q[{s1_idx_q, 1'b0} +: 2];
      s2_oob_q  <= s1_oob_q;
    end
  end

  assign query_out_valid = qo_valid_q;
  assign query_out_base  = qo_base_q;
  assign query_oob       = qo_oob_q;

endmodule

// File: tb/tb_read_store_buffer.sv
module tb_read_store_buffer;
  localparam int CL    = 512;
  localparam int MAXR  = 64;
  localparam int SEQ   = 2;
  localparam int BPL   = 64;
  localparam int RL    = 128;
  localparam int BEATS = SEQ + 2;

  logic         clk = 1'b0;
  logic         reset_n, stall, batch_start, batch_clear, load_valid;
  logic [6:0]   batch_size;
  logic [511:0] load_data;
  logic         new_read_ready, query_valid;
  logic [5:0]   query_read_num;
  logic [6:0]   query_position;
  logic         load_ready, load_done, new_read_valid, query_out_valid, query_oob;
  logic [5:0]   new_read_num;
  logic [63:0]  new_ik_x0, new_ik_x1, new_ik_x2, new_ik_info;
  logic [6:0]   new_forward_i, new_min_intv;
  logic [6:0]   reads_remaining;
  logic [7:0]   query_out_base;
  logic [63:0]  primary, L2_0, L2_1, L2_2, L2_3;

  always #5 clk = ~clk;

  read_store_buffer dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .batch_start(batch_start),
    .batch_size(batch_size), .batch_clear(batch_clear), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data), .load_done(load_done),
    .new_read_ready(new_read_ready), .new_read_valid(new_read_valid),
    .new_read_num(new_read_num), .new_ik_x0(new_ik_x0), .new_ik_x1(new_ik_x1),
    .new_ik_x2(new_ik_x2), .new_ik_info(new_ik_info), .new_forward_i(new_forward_i),
    .new_min_intv(new_min_intv), .reads_remaining(reads_remaining),
    .query_valid(query_valid), .query_read_num(query_read_num),
    .query_position(query_position), .query_out_valid(query_out_valid),
    .query_out_base(query_out_base), .query_oob(query_oob), .primary(primary),
    .L2_0(L2_0), .L2_1(L2_1), .L2_2(L2_2), .L2_3(L2_3)
  );

  // Behavioural model: batch described by its size, a flat count of accepted
  // beats and a dispatch index; storage kept as plain per-base arrays.
  typedef struct packed {logic v; logic o; logic [7:0] b;} qres_t;
  localparam qres_t QINV = '{v: 1'b0, o: 1'b0, b: 8'hFF};

  int           mstate;  // 0 idle, 1 load, 2 serve
  int           mN, mptr, mbeats;
  logic [1:0]   mbase  [MAXR][RL];
  logic [511:0] mparam [MAXR];
  logic [511:0] mik    [MAXR];
  bit           mp0_ok = 1'b0, mk0_ok = 1'b0;
  qres_t        mq_pipe[$];
  qres_t        mq_out;

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int    r, k;
    qres_t q;
    if (!reset_n) begin
      mstate = 0; mN = 0; mptr = 0; mbeats = 0;
      mq_pipe = {};
      mq_pipe.push_back(QINV);
      mq_pipe.push_back(QINV);
      mq_out = QINV;
    end else begin
      // Query result is fixed by the state before this edge.
      if (!stall) begin
        q.v = query_valid;
        q.o = query_valid && (mstate != 2 || int'(query_read_num) >= mN ||
                              int'(query_position) >= RL);
        q.b = (!query_valid || q.o) ? 8'hFF : {6'b0, mbase[query_read_num][query_position]};
        mq_pipe.push_back(q);
        mq_out = mq_pipe.pop_front();
      end
      case (mstate)
        0: if (batch_start && batch_size != 0) begin
          mN = (int'(batch_size) > MAXR) ? MAXR : int'(batch_size);
          mbeats = 0;
          mstate = 1;
        end
        1: if (load_valid) begin
          r = mbeats / BEATS;
          k = mbeats % BEATS;
          if (k < SEQ) begin
            for (int i = 0; i < BPL; i++) mbase[r][k*BPL+i] = load_data[8*i +: 2];
          end else if (k == SEQ) begin
            mparam[r] = load_data;
            if (r == 0) mp0_ok = 1'b1;
          end else begin
            mik[r] = load_data;
            if (r == 0) mk0_ok = 1'b1;
          end
          mbeats++;
          if (mbeats == mN * BEATS) mstate = 2;
        end
        2: if (batch_clear) begin
          mstate = 0;
          mptr = 0;
        end else if (mptr < mN && new_read_ready && !stall) begin
          mptr++;
        end
        default: mstate = 0;
      endcase
    end
  end

  always @(negedge clk) begin : compare
    bit v;
    int ix;
    if (chk_en) begin
      v  = (mstate == 2) && (mptr < mN);
      ix = v ? mptr : 0;
      chk("load_ready", load_ready, mstate == 1);
      chk("load_done", load_done, mstate == 2);
      chk("new_read_valid", new_read_valid, v);
      chk("new_read_num", new_read_num, v ? mptr : 63);
      chk("ik_x0", new_ik_x0, v ? mik[ix][63:0] : 64'h1111_1111_1111_1111);
      chk("ik_x1", new_ik_x1, v ? mik[ix][127:64] : 64'h1111_1111_1111_1111);
      chk("ik_x2", new_ik_x2, v ? mik[ix][191:128] : 64'h1111_1111_1111_1111);
      chk("ik_info", new_ik_info, v ? mik[ix][255:192] : 64'h1111_1111_1111_1111);
      chk("forward_i", new_forward_i, v ? mparam[ix][6:0] : 7'h7F);
      chk("min_intv", new_min_intv, v ? mparam[ix][70:64] : 7'h7F);
      chk("reads_remaining", reads_remaining, (mstate == 2) ? mN - mptr : 0);
      chk("query_out_valid", query_out_valid, mq_out.v);
      chk("query_oob", query_oob, mq_out.o);
      chk("query_out_base", query_out_base, mq_out.b);
      if (mp0_ok) chk("primary", primary, mparam[0][191:128]);
      if (mk0_ok) begin
        chk("L2_0", L2_0, mik[0][319:256]);
        chk("L2_1", L2_1, mik[0][383:320]);
        chk("L2_2", L2_2, mik[0][447:384]);
        chk("L2_3", L2_3, mik[0][511:448]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [511:0] rnd_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom();
    return l;
  endfunction

  task automatic start_batch(input int sz);
    batch_start = 1'b1;
    batch_size  = 7'(sz);
    cyc();
    batch_start = 1'b0;
  endtask

  // Random beats plus ignored start/clear pulses and out-of-state queries.
  task automatic load_all(input int pct, input int budget);
    int n = 0;
    while (mstate == 1 && n < budget) begin
      load_valid     = ($urandom_range(0, 99) < pct);
      load_data      = rnd_line();
      batch_clear    = ($urandom_range(0, 7) == 0);
      batch_start    = ($urandom_range(0, 7) == 0);
      batch_size     = 7'($urandom);
      query_valid    = $urandom_range(0, 1);
      query_read_num = 6'($urandom);
      query_position = 7'($urandom);
      cyc();
      n++;
    end
    load_valid = 0; batch_clear = 0; batch_start = 0; query_valid = 0;
    chk("load_done_after_load", load_done, 1);
  endtask

  task automatic serve_random(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      new_read_ready = $urandom_range(0, 1);
      stall          = ($urandom_range(0, 9) == 0);
      query_valid    = ($urandom_range(0, 3) != 0);
      query_read_num = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, mN));
      query_position = 7'($urandom);
      cyc();
    end
    new_read_ready = 0; stall = 0; query_valid = 0;
    repeat (4) cyc();
  endtask

  initial begin
    int nrdy, nv;
    logic [511:0] ld;
    reset_n = 0; stall = 0; batch_start = 0; batch_clear = 0; batch_size = 0;
    load_valid = 0; load_data = '0; new_read_ready = 0;
    query_valid = 0; query_read_num = 0; query_position = 0;
    repeat (3) cyc();
    reset_n = 1;
    chk_en  = 1;
    chk("rst_load_ready", load_ready, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_qbase", query_out_base, 8'hFF);
    chk("rst_remaining", reads_remaining, 0);

    start_batch(0);
    chk("size0_noop", load_ready, 0);

    // Load 3 reads, load_valid held high
    start_batch(3);
    load_valid = 1;
    nrdy = 0;
    for (int i = 0; i < 16; i++) begin
      if (load_ready) nrdy++;
      ld = rnd_line();
      if (i == 5) ld[55:48] = 8'hA3;  // read 1, position 70
      load_data = ld;
      cyc();
    end
    load_valid = 0;
    chk("ready_cycles", nrdy, 12);
    chk("load_done_n3", load_done, 1);
    chk("remaining_n3", reads_remaining, 3);

    // Dispatch with a 2-cycle stall
    chk("disp_num0", new_read_num, 0);
    new_read_ready = 1;
    cyc(); chk("disp_num1", new_read_num, 1);
    stall = 1;
    cyc(); chk("stall_hold_a", new_read_num, 1);
    cyc(); chk("stall_hold_b", new_read_num, 1);
    stall = 0;
    cyc(); chk("disp_num2", new_read_num, 2);
    cyc();
    chk("disp_end_valid", new_read_valid, 0);
    chk("disp_end_x0", new_ik_x0, 64'h1111_1111_1111_1111);
    chk("disp_end_num", new_read_num, 6'h3F);
    new_read_ready = 0;

    // Single query, 3-cycle latency
    query_valid = 1; query_read_num = 1; query_position = 70;
    cyc();
    query_valid = 0;
    cyc(); chk("q_lat_early", query_out_valid, 0);
    cyc();
    chk("q_lat_valid", query_out_valid, 1);
    chk("q_a3_base", query_out_base, 8'h03);

    // Back-to-back stream
    nv = 0;
    for (int i = 0; i < 68; i++) begin
      query_valid    = (i < 64);
      query_read_num = 6'($urandom_range(0, 2));
      query_position = 7'(i);
      cyc();
      if (query_out_valid) nv++;
    end
    chk("stream_count", nv, 64);

    // Out-of-range read number
    query_valid = 1; query_read_num = 3; query_position = 5;
    cyc();
    query_valid = 0;
    cyc(); cyc();
    chk("oob_flag", query_oob, 1);
    chk("oob_base", query_out_base, 8'hFF);

    // Stall mid-pipeline delays the result by the stall length
    query_valid = 1; query_read_num = 0; query_position = 0;
    cyc();
    query_valid = 0; stall = 1;
    cyc(); cyc();
    stall = 0;
    cyc(); chk("stall_q_early", query_out_valid, 0);
    cyc();
    chk("stall_q_valid", query_out_valid, 1);
    chk("stall_q_oob", query_oob, 0);

    serve_random(300);

    // Clear, query in IDLE, clamped batch
    batch_clear = 1; cyc(); batch_clear = 0;
    chk("clear_done", load_done, 0);
    query_valid = 1; query_read_num = 0; query_position = 0;
    cyc();
    query_valid = 0;
    cyc(); cyc();
    chk("idle_q_oob", query_oob, 1);
    start_batch(100);
    load_all(70, 2000);
    chk("clamp_remaining", reads_remaining, 64);
    serve_random(400);

    // Re-batch of one read
    batch_clear = 1; cyc(); batch_clear = 0;
    start_batch(1);
    load_all(100, 50);
    chk("rebatch_num", new_read_num, 0);
    chk("rebatch_remaining", reads_remaining, 1);
    batch_start = 1; batch_size = 5; cyc(); batch_start = 0;
    chk("start_in_serve", reads_remaining, 1);
    serve_random(60);

    // Reset in the middle of a load
    batch_clear = 1; cyc(); batch_clear = 0;
    start_batch(2);
    load_valid = 1;
    for (int i = 0; i < 5; i++) begin
      load_data = rnd_line();
      cyc();
    end
    load_valid = 0; reset_n = 0;
    cyc();
    reset_n = 1;
    chk("midrst_ready", load_ready, 0);
    chk("midrst_done", load_done, 0);
    chk("midrst_valid", new_read_valid, 0);
    start_batch(2);
    load_all(80, 100);
    serve_random(80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
